// File: rtl/head_flit_queue_decoder_pkg.sv
// -----------------------------------------------------------------------------
// head_flit_queue_decoder_pkg
// Shared definitions for the head-flit queue/decoder slice.
//   port_e     : encoding of the output-port request sent to the switch allocator
//   dest_width : number of low header bits that hold the destination node ID
// -----------------------------------------------------------------------------
package head_flit_queue_decoder_pkg;

   // Output-port request encoding. PORT_RSVD is never produced by the router.
   typedef enum logic [1:0] {
      PORT_LOCAL = 2'd0,
      PORT_INC   = 2'd1,
      PORT_DEC   = 2'd2,
      PORT_RSVD  = 2'd3
   } port_e;

   // Width of the destination field for a network of 'nodes' nodes.
   // A one-node or two-node network still needs a single bit.
   function automatic int dest_width(input int nodes);
      return (nodes <= 2) ? 1 : $clog2(nodes);
   endfunction

endpackage

// File: rtl/head_flit_queue_decoder_if.sv
// -----------------------------------------------------------------------------
// head_flit_queue_decoder_if
// Bundles the control-side handshake of the head-flit queue/decoder.
//   master : input-port control FSM (drives push/pop/decode strobes)
//   slave  : head_flit_queue_decoder (returns FIFO status, head phit, request)
// Signals:
//   wr_en/din   push a header phit
//   rd_en       pop the oldest entry
//   full/empty/count/dout  FIFO status and first-word-fall-through head
//   decode      request decode of dout
//   request/decoded  registered output-port request and its one-cycle pulse
// -----------------------------------------------------------------------------
interface head_flit_queue_decoder_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int REQUEST_WIDTH = 2
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                     wr_en;
   logic [DATA_WIDTH-1:0]    din;
   logic                     rd_en;
   logic                     full;
   logic                     empty;
   logic [DATA_WIDTH-1:0]    dout;
   logic [CNT_W-1:0]         count;
   logic                     decode;
   logic [REQUEST_WIDTH-1:0] request;
   logic                     decoded;

   modport master (
      output wr_en, din, rd_en, decode,
      input  full, empty, dout, count, request, decoded
   );

   modport slave (
      input  wr_en, din, rd_en, decode,
      output full, empty, dout, count, request, decoded
   );

endinterface

// File: rtl/head_flit_queue_decoder_hfq_fifo.sv
// -----------------------------------------------------------------------------
// hfq_fifo
// First-word-fall-through circular buffer holding header phits.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   wr_en, din      push (accepted when not full, or when popping the same cycle)
//   rd_en           pop (accepted when not empty)
//   full, empty     occupancy flags
//   count           current occupancy, 0..FIFO_DEPTH
//   dout            oldest entry, 0 while empty
// -----------------------------------------------------------------------------
module hfq_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          rd_en,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [DATA_WIDTH-1:0]         dout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic                  do_write;
   logic                  do_read;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rptr_q];

   // A push into a full buffer is still taken when a pop frees the head slot
   // in the same cycle; pointers wrap naturally because the depth is a power of two.
   always_comb begin
      do_read  = rd_en & ~empty;
      do_write = wr_en & (~full | rd_en);

      wptr_d  = do_write ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_read  ? rptr_q + AW'(1) : rptr_q;

      count_d = count_q;
      case ({do_write, do_read})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      mem_d = mem_q;
      if (do_write) begin
         mem_d[wptr_q] = din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: dout is forced to 0 whenever the buffer is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/head_flit_queue_decoder.sv
// -----------------------------------------------------------------------------
// head_flit_queue_decoder
// Per-VC head-flit front end of a router input port: a FWFT header FIFO plus a
// 1D routing decoder that turns the oldest header into an output-port request.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       head_flit_queue_decoder_if.slave (push/pop/decode strobes in,
//             FIFO status, head phit, request and decoded pulse out)
// The interface instance must use the same DATA_WIDTH, FIFO_DEPTH and
// REQUEST_WIDTH as this module.
// -----------------------------------------------------------------------------
module head_flit_queue_decoder
   import head_flit_queue_decoder_pkg::*;
#(
   parameter int N             = 4,
   parameter int INDEX         = 1,
   parameter int DATA_WIDTH    = 8,
   parameter int PhitPerFlit   = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int REQUEST_WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   head_flit_queue_decoder_if.slave   bus
);

   localparam int          DEST_W  = dest_width(N);
   localparam logic [31:0] INDEX_U = 32'(INDEX);

   // Elaboration-time sanity check of the parameter set.
   if (PhitPerFlit < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       REQUEST_WIDTH < 2 || INDEX < 0 || INDEX >= N || DEST_W > DATA_WIDTH) begin : g_bad_params
      $error("head_flit_queue_decoder: illegal parameter combination");
   end

   logic [DATA_WIDTH-1:0]    head;
   logic [DEST_W-1:0]        dest;
   logic [31:0]              dest_ext;
   port_e                    route;
   logic [REQUEST_WIDTH-1:0] request_q, request_d;
   logic                     decoded_q, decoded_d;

   hfq_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (bus.wr_en),
      .din   (bus.din),
      .rd_en (bus.rd_en),
      .full  (bus.full),
      .empty (bus.empty),
      .count (bus.count),
      .dout  (head)
   );

   assign bus.dout    = head;
   assign bus.request = request_q;
   assign bus.decoded = decoded_q;

   assign dest     = head[DEST_W-1:0];
   assign dest_ext = 32'(dest);

   // Only the destination field matters for routing; the rest of the header is
   // carried through dout untouched.
   if (DATA_WIDTH > DEST_W) begin : g_unused_hdr
      logic unused_hdr_bits;
      assign unused_hdr_bits = ^head[DATA_WIDTH-1:DEST_W];
   end

   // Linear 1D routing: eject at home, otherwise move toward the destination ID.
   always_comb begin
      route = PORT_LOCAL;
      if (dest_ext > INDEX_U) begin
         route = PORT_INC;
      end else if (dest_ext < INDEX_U) begin
         route = PORT_DEC;
      end
   end

   // A decode is only honoured with a valid head; it samples the pre-pop dout,
   // so a simultaneous rd_en does not disturb it. request holds otherwise.
   always_comb begin
      request_d = request_q;
      decoded_d = 1'b0;
      if (bus.decode && !bus.empty) begin
         request_d = REQUEST_WIDTH'(route);
         decoded_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         request_q <= '0;
         decoded_q <= 1'b0;
      end else begin
         request_q <= request_d;
         decoded_q <= decoded_d;
      end
   end

endmodule

// File: tb/tb_head_flit_queue_decoder.sv
// -----------------------------------------------------------------------------
// tb_head_flit_queue_decoder
// Self-checking bench: directed header sequences followed by random traffic,
// every cycle compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_head_flit_queue_decoder;

   localparam int N             = 4;
   localparam int INDEX         = 1;
   localparam int DATA_WIDTH    = 8;
   localparam int FIFO_DEPTH    = 4;
   localparam int REQUEST_WIDTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   head_flit_queue_decoder_if #(
      .DATA_WIDTH    (DATA_WIDTH),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .REQUEST_WIDTH (REQUEST_WIDTH)
   ) bus ();

   head_flit_queue_decoder #(
      .N             (N),
      .INDEX         (INDEX),
      .DATA_WIDTH    (DATA_WIDTH),
      .PhitPerFlit   (2),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .REQUEST_WIDTH (REQUEST_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int num_checks = 0;
   int num_errors = 0;

   // Reference model state: queue contents, last request, decoded pulse.
   int model_q[$];
   int model_request = 0;
   int model_decoded = 0;

   function automatic int route_of(input int header);
      int dest;
      dest = header % N;
      if (dest == INDEX) return 0;
      if (dest > INDEX)  return 1;
      return 2;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      int exp_cnt;
      exp_cnt = model_q.size();
      checkOutput("count",   int'(bus.count),   exp_cnt);
      checkOutput("empty",   int'(bus.empty),   (exp_cnt == 0) ? 1 : 0);
      checkOutput("full",    int'(bus.full),    (exp_cnt == FIFO_DEPTH) ? 1 : 0);
      checkOutput("dout",    int'(bus.dout),    (exp_cnt == 0) ? 0 : model_q[0]);
      checkOutput("request", int'(bus.request), model_request);
      checkOutput("decoded", int'(bus.decoded), model_decoded);
   endtask

   // Model update for one clock edge, from the state before the edge.
   task automatic modelStep(input bit r, input bit wr, input int d, input bit rd, input bit dec);
      bit was_empty, was_full;
      if (r) begin
         model_q.delete();
         model_request = 0;
         model_decoded = 0;
         return;
      end
      was_empty = (model_q.size() == 0);
      was_full  = (model_q.size() == FIFO_DEPTH);
      model_decoded = (dec && !was_empty) ? 1 : 0;
      if (dec && !was_empty) model_request = route_of(model_q[0]);
      if (rd && !was_empty) void'(model_q.pop_front());
      if (wr && (!was_full || rd)) model_q.push_back(d);
   endtask

   // Check current outputs, drive one cycle of inputs, then advance model.
   task automatic applyStimulus(input bit r, input bit wr, input int d, input bit rd, input bit dec);
      @(negedge clk);
      checkAll();
      rst        = r;
      bus.wr_en  = wr;
      bus.din    = DATA_WIDTH'(d);
      bus.rd_en  = rd;
      bus.decode = dec;
      @(posedge clk);
      modelStep(r, wr, d, rd, dec);
   endtask

   initial begin
      bus.wr_en  = 1'b0;
      bus.din    = '0;
      bus.rd_en  = 1'b0;
      bus.decode = 1'b0;
      rst        = 1'b1;
      repeat (2) @(posedge clk);
      modelStep(1'b1, 1'b0, 0, 1'b0, 1'b0);

      // Idle after reset.
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Fill to full, then an ignored fifth push.
      applyStimulus(0, 1, 8'h03, 0, 0);
      applyStimulus(0, 1, 8'h00, 0, 0);
      applyStimulus(0, 1, 8'h01, 0, 0);
      applyStimulus(0, 1, 8'h02, 0, 0);
      applyStimulus(0, 1, 8'h07, 0, 0);

      // Simultaneous push/pop while full, drain, then pop from empty.
      applyStimulus(0, 1, 8'h05, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 1, 8'h09, 1, 0);

      // Routing: 0x09 ejects (dest 1), then queue 0x03, 0x01, 0x00.
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 1, 8'h03, 0, 0);
      applyStimulus(0, 1, 8'h01, 0, 0);
      applyStimulus(0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         applyStimulus(0, 0, 0, 1, 0);
      end

      // Decode while empty, then push 0x01 and decode.
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 8'h01, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);

      // Back-to-back decodes with a pop in the same cycle.
      applyStimulus(0, 1, 8'h02, 0, 0);
      applyStimulus(0, 1, 8'h00, 0, 1);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);

      // Reset with three entries queued and decode high.
      applyStimulus(0, 1, 8'h03, 0, 0);
      applyStimulus(0, 1, 8'h02, 0, 0);
      applyStimulus(0, 1, 8'h00, 0, 1);
      applyStimulus(1, 1, 8'h01, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) < 2),
                       ($urandom_range(0, 99) < 60),
                       int'($urandom_range(0, 255)),
                       ($urandom_range(0, 99) < 50),
                       ($urandom_range(0, 99) < 40));
      end

      @(negedge clk);
      checkAll();

      $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
      $finish;
   end

endmodule
